seq_control_unit: RTL and testbench

Parametrised successor to the processor's fixed-opcode control FSM. It sequences fetch, operand fetch, execute and halt for the 8-bit accumulator datapath. It supports a variable-latency memory handshake, register-indexed instructions over NUM_REGS general registers, and two conditional jumps. It drives the datapath B-bus select, ALU opcode and one-hot load enables, and sits between instruction memory/RAM and the datapath.

---
 rtl/seq_cu_pkg.sv | 60 ++++++
 rtl/seq_cu_watchdog.sv | 27 ++
 rtl/seq_control_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_seq_control_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_cu_pkg.sv
// rtl/seq_cu_pkg.sv - shared encodings for the sequencing control unit
package seq_cu_pkg;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_CLAC    = 4'd1;
  localparam logic [3:0] OP_LDAC    = 4'd2;
  localparam logic [3:0] OP_STAC    = 4'd3;
  localparam logic [3:0] OP_MVAC    = 4'd4;
  localparam logic [3:0] OP_MVR     = 4'd5;
  localparam logic [3:0] OP_INC     = 4'd6;
  localparam logic [3:0] OP_ADD     = 4'd7;
  localparam logic [3:0] OP_SUB     = 4'd8;
  localparam logic [3:0] OP_MUL4    = 4'd9;
  localparam logic [3:0] OP_DIV2    = 4'd10;
  localparam logic [3:0] OP_JPNZ    = 4'd11;
  localparam logic [3:0] OP_JPN     = 4'd12;
  localparam logic [3:0] OP_ADDM    = 4'd13;
  localparam logic [3:0] OP_ILLEGAL = 4'd14;
  localparam logic [3:0] OP_END     = 4'd15;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_PASS = 3'd2;
  localparam logic [2:0] ALU_ZERO = 3'd3;
  localparam logic [2:0] ALU_INC  = 3'd4;
  localparam logic [2:0] ALU_MUL4 = 3'd5;
  localparam logic [2:0] ALU_DIV2 = 3'd6;

  // Fixed B-bus sources; general register i sits at B_R_BASE + i.
  typedef enum logic [1:0] {
    B_RAM = 2'd0,
    B_PC  = 2'd1,
    B_AC  = 2'd2,
    B_AR  = 2'd3
  } bbase_t;
  localparam int B_R_BASE = 4;

  localparam int SEL_PC_LD  = 0;
  localparam int SEL_PC_INC = 1;
  localparam int SEL_IR_LD  = 2;
  localparam int SEL_AC_LD  = 3;
  localparam int SEL_AR_LD  = 4;
  localparam int SEL_R_BASE = 5;

  typedef enum logic [2:0] {
    S_F_ADDR  = 3'd0,
    S_F_WAIT  = 3'd1,
    S_DECODE  = 3'd2,
    S_OP_ADDR = 3'd3,
    S_OP_WAIT = 3'd4,
    S_M_WAIT  = 3'd5,
    S_HALT    = 3'd6,
    S_TRAP    = 3'd7
  } state_t;

  function automatic logic is_reg_op(input logic [3:0] op);
    return (op >= OP_MVAC) && (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/seq_cu_watchdog.sv
// rtl/seq_cu_watchdog.sv - wait-state counter; pulses timeout on the TIMEOUT_CYCLES-th idle wait cycle
module seq_cu_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  // count holds the idle cycles already seen, so this fires on the limit cycle itself
  assign timeout = tick && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - fetch/operand/execute sequencer for the accumulator datapath
// Optional wait-state watchdog enabled by defining SEQ_CU_WATCHDOG_EN.
module seq_control_unit
  import seq_cu_pkg::*;
#(
  parameter int NUM_REGS       = 4,
  parameter int BSEL_W         = $clog2(NUM_REGS + 4),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [7:0]          INSTRUCTION,
  input  logic                FLAG_Z,
  input  logic                FLAG_N,
  input  logic                MEM_READY,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [BSEL_W-1:0]   REG_IN_B_BUS,
  output logic [2:0]          ALU_OP,
  output logic [NUM_REGS+4:0] SELECTORS,
  output logic                FINISH,
  output logic                ERROR
);

  localparam int NSEL = NUM_REGS + 5;

  state_t state;
  state_t state_next;
  logic [3:0] op_q;
  logic [3:0] op;
  logic [3:0] idx;
  logic bad_idx;
  logic timeout;
  logic [BSEL_W-1:0] reg_b;

  logic mem_req;
  logic mem_we;
  logic [BSEL_W-1:0] b_sel;
  logic [2:0] alu_op;
  logic [NSEL-1:0] sel;
  logic finish;
  logic error;

  assign op      = INSTRUCTION[7:4];
  assign idx     = INSTRUCTION[3:0];
  assign bad_idx = is_reg_op(op) && (int'(idx) >= NUM_REGS);
  assign reg_b   = BSEL_W'(B_R_BASE + int'(idx));

  function automatic logic [NSEL-1:0] bit_at(input int pos);
    return NSEL'(1) << pos;
  endfunction

`ifdef SEQ_CU_WATCHDOG_EN
  logic in_wait;
  assign in_wait = (state == S_F_WAIT) || (state == S_OP_WAIT) || (state == S_M_WAIT);

  seq_cu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLOCK),
    .rst    (RESET),
    .clear  (!in_wait || MEM_READY),
    .tick   (in_wait && !MEM_READY),
    .timeout(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= S_F_ADDR;
      op_q  <= OP_NOP;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q <= op;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    b_sel      = BSEL_W'(B_RAM);
    alu_op     = ALU_PASS;
    sel        = '0;
    finish     = 1'b0;
    error      = 1'b0;

    case (state)
      S_F_ADDR: begin
        b_sel      = BSEL_W'(B_PC);
        sel        = bit_at(SEL_AR_LD);
        state_next = S_F_WAIT;
      end

      S_F_WAIT: begin
        mem_req = 1'b1;
        if (MEM_READY) begin
          sel        = bit_at(SEL_IR_LD) | bit_at(SEL_PC_INC);
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        state_next = S_F_ADDR;
        // An out-of-range register index must not touch any load enable.
        if (bad_idx) begin
          state_next = S_TRAP;
        end else begin
          case (op)
            OP_CLAC: begin
              alu_op = ALU_ZERO;
              sel    = bit_at(SEL_AC_LD);
            end
            OP_LDAC, OP_STAC, OP_JPNZ, OP_JPN, OP_ADDM: begin
              state_next = S_OP_ADDR;
            end
            OP_MVAC: begin
              b_sel = BSEL_W'(B_AC);
              sel   = bit_at(SEL_R_BASE + int'(idx));
            end
            OP_MVR: begin
              b_sel = reg_b;
              sel   = bit_at(SEL_AC_LD);
            end
            OP_INC: begin
              b_sel  = reg_b;
              alu_op = ALU_INC;
              sel    = bit_at(SEL_R_BASE + int'(idx));
            end
            OP_ADD: begin
              b_sel  = reg_b;
              alu_op = ALU_ADD;
              sel    = bit_at(SEL_AC_LD);
            end
            OP_SUB: begin
              b_sel  = reg_b;
              alu_op = ALU_SUB;
              sel    = bit_at(SEL_AC_LD);
            end
            OP_MUL4: begin
              alu_op = ALU_MUL4;
              sel    = bit_at(SEL_AC_LD);
            end
            OP_DIV2: begin
              alu_op = ALU_DIV2;
              sel    = bit_at(SEL_AC_LD);
            end
            OP_ILLEGAL: state_next = S_TRAP;
            OP_END:     state_next = S_HALT;
            default: ;
          endcase
        end
      end

      S_OP_ADDR: begin
        b_sel      = BSEL_W'(B_PC);
        sel        = bit_at(SEL_AR_LD);
        state_next = S_OP_WAIT;
      end

      S_OP_WAIT: begin
        mem_req = 1'b1;
        if (MEM_READY) begin
          if (op_q == OP_JPNZ) begin
            sel        = !FLAG_Z ? bit_at(SEL_PC_LD) : bit_at(SEL_PC_INC);
            state_next = S_F_ADDR;
          end else if (op_q == OP_JPN) begin
            sel        = FLAG_N ? bit_at(SEL_PC_LD) : bit_at(SEL_PC_INC);
            state_next = S_F_ADDR;
          end else begin
            // Operand word is the data address: move it into AR and skip past it.
            sel        = bit_at(SEL_AR_LD) | bit_at(SEL_PC_INC);
            state_next = S_M_WAIT;
          end
        end
      end

      S_M_WAIT: begin
        mem_req = 1'b1;
        if (op_q == OP_STAC) begin
          mem_we = 1'b1;
          b_sel  = BSEL_W'(B_AC);
        end else if (op_q == OP_ADDM) begin
          alu_op = ALU_ADD;
        end
        if (MEM_READY) begin
          if (op_q != OP_STAC) begin
            sel = bit_at(SEL_AC_LD);
          end
          state_next = S_F_ADDR;
        end
      end

      S_HALT: begin
        finish = 1'b1;
      end

      default: begin
        finish = 1'b1;
        error  = 1'b1;
      end
    endcase

    if (timeout) begin
      state_next = S_TRAP;
    end
  end

  // Reset overrides the decode combinationally so an in-flight request drops immediately.
  assign MEM_REQ      = RESET ? 1'b0 : mem_req;
  assign MEM_WE       = RESET ? 1'b0 : mem_we;
  assign REG_IN_B_BUS = RESET ? '0 : b_sel;
  assign ALU_OP       = RESET ? ALU_PASS : alu_op;
  assign SELECTORS    = RESET ? '0 : sel;
  assign FINISH       = RESET ? 1'b0 : finish;
  assign ERROR        = RESET ? 1'b0 : error;

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - randomized self-checking bench against a per-instruction cycle model
module tb_seq_control_unit;

  localparam int NR   = 4;
  localparam int BW   = $clog2(NR + 4);
  localparam int NSEL = NR + 5;
  localparam int TMO  = 8;
`ifdef SEQ_CU_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int PCL = 1, PCI = 2, IRL = 4, ACL = 8, ARL = 16;

  logic            CLOCK = 1'b0;
  logic            RESET;
  logic [7:0]      INSTRUCTION;
  logic            FLAG_Z;
  logic            FLAG_N;
  logic            MEM_READY;
  logic            MEM_REQ;
  logic            MEM_WE;
  logic [BW-1:0]   REG_IN_B_BUS;
  logic [2:0]      ALU_OP;
  logic [NSEL-1:0] SELECTORS;
  logic            FINISH;
  logic            ERROR;

  always #5 CLOCK = ~CLOCK;

  seq_control_unit #(
    .NUM_REGS(NR),
    .BSEL_W(BW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .INSTRUCTION(INSTRUCTION),
    .FLAG_Z(FLAG_Z),
    .FLAG_N(FLAG_N),
    .MEM_READY(MEM_READY),
    .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE),
    .REG_IN_B_BUS(REG_IN_B_BUS),
    .ALU_OP(ALU_OP),
    .SELECTORS(SELECTORS),
    .FINISH(FINISH),
    .ERROR(ERROR)
  );

  typedef struct packed {
    logic            req;
    logic            we;
    logic            fin;
    logic            err;
    logic [2:0]      alu;
    logic [BW-1:0]   b;
    logic [NSEL-1:0] sel;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t mk(input logic req, input logic we, input int b, input int alu, input int sel);
    exp_t e;
    e.req = req;
    e.we  = we;
    e.fin = 1'b0;
    e.err = 1'b0;
    e.alu = 3'(alu);
    e.b   = BW'(b);
    e.sel = NSEL'(sel);
    return e;
  endfunction

  // One clock: drive MEM_READY, compare all outputs mid-cycle, advance to 1 unit after the edge.
  task automatic cyc(input string tag, input logic rdy, input exp_t e);
    exp_t o;
    MEM_READY = rdy;
    #2;
    o = {MEM_REQ, MEM_WE, FINISH, ERROR, ALU_OP, REG_IN_B_BUS, SELECTORS};
    check(tag, 32'(o), 32'(e));
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    for (int i = 0; i < n; i++) begin
      FLAG_Z = 1'($urandom);
      FLAG_N = 1'($urandom);
      cyc("reset", 1'($urandom), mk(0, 0, 0, 2, 0));
    end
    RESET = 1'b0;
  endtask

  task automatic hold_end(input string tag, input logic err);
    exp_t e;
    e = mk(0, 0, 0, 2, 0);
    e.fin = 1'b1;
    e.err = err;
    for (int i = 0; i < 3; i++) cyc(tag, 1'($urandom), e);
    do_reset(1 + $urandom_range(0, 2));
  endtask

  // waits = idle cycles before MEM_READY; the watchdog (if built) trips after TMO idle cycles.
  task automatic wait_phase(input string tag, input int waits, input exp_t busy, input exp_t done,
                            output bit timed_out);
    timed_out = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      if (WD && k == TMO) begin
        timed_out = 1'b1;
        return;
      end
      cyc(tag, k == waits, (k == waits) ? done : busy);
    end
  endtask

  // cls: 0 single-cycle, 1 needs operand, 2 halt, 3 trap
  task automatic decode_exp(input logic [7:0] ins, output exp_t e, output int cls);
    int op;
    int idx;
    op  = int'(ins[7:4]);
    idx = int'(ins[3:0]);
    e   = mk(0, 0, 0, 2, 0);
    cls = 0;
    if (op >= 4 && op <= 8 && idx >= NR) begin
      cls = 3;
      return;
    end
    case (op)
      1:  e = mk(0, 0, 0, 3, ACL);
      2, 3, 11, 12, 13: cls = 1;
      4:  e = mk(0, 0, 2, 2, 32 << idx);
      5:  e = mk(0, 0, 4 + idx, 2, ACL);
      6:  e = mk(0, 0, 4 + idx, 4, 32 << idx);
      7:  e = mk(0, 0, 4 + idx, 0, ACL);
      8:  e = mk(0, 0, 4 + idx, 1, ACL);
      9:  e = mk(0, 0, 0, 5, ACL);
      10: e = mk(0, 0, 0, 6, ACL);
      14: cls = 3;
      15: cls = 2;
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [7:0] ins, input int wf, input int wo, input int wm,
                           input logic z, input logic n);
    exp_t e;
    exp_t busy;
    exp_t done;
    int cls;
    int op;
    bit to;
    bit taken;
    op = int'(ins[7:4]);
    INSTRUCTION = 8'($urandom);
    FLAG_Z = 1'($urandom);
    FLAG_N = 1'($urandom);
    cyc("f_addr", 1'($urandom), mk(0, 0, 1, 2, ARL));
    wait_phase("f_wait", wf, mk(1, 0, 0, 2, 0), mk(1, 0, 0, 2, IRL | PCI), to);
    if (to) begin
      hold_end("wd_trap", 1'b1);
      return;
    end
    INSTRUCTION = ins;
    decode_exp(ins, e, cls);
    cyc("decode", 1'($urandom), e);
    if (cls == 2) begin
      hold_end("halt", 1'b0);
      return;
    end
    if (cls == 3) begin
      hold_end("trap", 1'b1);
      return;
    end
    if (cls == 0) return;
    cyc("op_addr", 1'($urandom), mk(0, 0, 1, 2, ARL));
    FLAG_Z = z;
    FLAG_N = n;
    if (op == 11 || op == 12) begin
      taken = (op == 11) ? !z : n;
      done  = mk(1, 0, 0, 2, taken ? PCL : PCI);
    end else begin
      done  = mk(1, 0, 0, 2, ARL | PCI);
    end
    wait_phase("op_wait", wo, mk(1, 0, 0, 2, 0), done, to);
    if (to) begin
      hold_end("wd_trap", 1'b1);
      return;
    end
    if (op == 11 || op == 12) return;
    FLAG_Z = 1'($urandom);
    FLAG_N = 1'($urandom);
    if (op == 3) begin
      busy = mk(1, 1, 2, 2, 0);
      done = busy;
    end else begin
      busy = mk(1, 0, 0, (op == 13) ? 0 : 2, 0);
      done = mk(1, 0, 0, (op == 13) ? 0 : 2, ACL);
    end
    wait_phase("m_wait", wm, busy, done, to);
    if (to) hold_end("wd_trap", 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no completion, expected summary before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] ins;
    int op;
    int idx;
    RESET       = 1'b1;
    INSTRUCTION = 8'h00;
    FLAG_Z      = 1'b0;
    FLAG_N      = 1'b0;
    MEM_READY   = 1'b0;
    @(posedge CLOCK);
    #1;
    do_reset(2);

    // Reset during a stalled fetch abandons the request.
    cyc("f_addr", 1'b0, mk(0, 0, 1, 2, ARL));
    cyc("f_wait", 1'b0, mk(1, 0, 0, 2, 0));
    cyc("f_wait", 1'b0, mk(1, 0, 0, 2, 0));
    MEM_READY = 1'b0;
    do_reset(3);

    run_instr(8'h72, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h72, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h20, 2, 2, 2, 1'b0, 1'b0);
    run_instr(8'hB0, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'hB0, 0, 1, 0, 1'b1, 1'b0);
    run_instr(8'hC0, 0, 0, 0, 1'b0, 1'b1);
    run_instr(8'hC0, 1, 0, 0, 1'b1, 1'b0);
    run_instr(8'h31, 0, 0, 3, 1'b0, 1'b0);
    run_instr(8'hD0, 1, 1, 1, 1'b0, 1'b0);
    run_instr(8'h4F, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h43, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h63, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'hF0, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'hE5, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h20, 0, 0, TMO, 1'b0, 1'b0);
    run_instr(8'h20, 0, 0, TMO - 1, 1'b0, 1'b0);
    run_instr(8'h90, TMO, 0, 0, 1'b0, 1'b0);
    run_instr(8'hA0, TMO - 1, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      op  = $urandom_range(0, 13);
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NR - 1);
      ins = {4'(op), 4'(idx)};
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
    end
    run_instr(8'hF3, 0, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
